// File: rtl/radio_seq_pkg.sv
// Shared types and default timing for the radio enable sequencer.
// Pure definitions; no logic, no latency, no flow control.
package radio_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISO_RELEASE,
    PLL_WAIT,
    RAMP,
    RX,
    DISABLE
  } state_t;

  localparam int DEF_BIT_WIDTH   = 2;
  localparam int DEF_ISO_CYCLES  = 4;
  localparam int DEF_RAMP_CYCLES = 8;
  localparam int DEF_PLL_TIMEOUT = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among N requesters, search starting at ptr.
// Purely combinational, zero latency; requesters hold req until served.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int              j;
  logic [IW-1:0]   idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!any && req[idx]) begin
        any        = 1'b1;
        gnt_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/radio_enable_sequencer.sv
// Arbitrates lane requests onto one radio/PLL and steps isolation, PLL settle, ramp and RX enable.
// Grant appears one cycle after a request is seen in IDLE; requests are levels, other lanes wait while busy.
module radio_enable_sequencer
  import radio_seq_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int ISO_CYCLES  = DEF_ISO_CYCLES,
  parameter int RAMP_CYCLES = DEF_RAMP_CYCLES,
  parameter int PLL_TIMEOUT = DEF_PLL_TIMEOUT
) (
  input  logic                 ck,
  input  logic                 arst,
  input  logic [BIT_WIDTH-1:0] req,
  input  logic [BIT_WIDTH-1:0] pllSettled,
  output logic [BIT_WIDTH-1:0] grant,
  output logic [BIT_WIDTH-1:0] radioEnable,
  output logic [BIT_WIDTH-1:0] radioRxEn,
  output logic                 isolate,
  output logic                 busy,
  output logic                 timeoutErr
);

  localparam int IW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam int CW = $clog2(max3(ISO_CYCLES, RAMP_CYCLES, PLL_TIMEOUT)) + 1;

  generate
    if (BIT_WIDTH < 1 || ISO_CYCLES < 1 || RAMP_CYCLES < 1 || PLL_TIMEOUT < 1) begin : g_bad_param
      $error("radio_enable_sequencer: all parameters must be >= 1");
    end
  endgenerate

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        sel_q, sel_d, ptr_q, ptr_d;
  logic [BIT_WIDTH-1:0] grant_q, grant_d, radio_en_q, radio_en_d, rx_en_q, rx_en_d;
  logic                 isolate_q, isolate_d, busy_q, busy_d, timeout_err_q, timeout_err_d;

  logic [BIT_WIDTH-1:0] arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 req_sel, settled_sel;

  rr_arbiter #(.N(BIT_WIDTH), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .grant   (arb_grant),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign req_sel     = req[sel_q];
  assign settled_sel = pllSettled[sel_q];

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    timeout_err_d = 1'b0;
    cnt_d         = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = ISO_RELEASE;
          sel_d   = arb_idx;
        end
      end
      ISO_RELEASE: begin
        if (!req_sel)          state_d = DISABLE;
        else if (cnt_q == '0)  state_d = PLL_WAIT;
      end
      PLL_WAIT: begin
        // A dropped request wins over a coincident timeout: no error reported.
        if (!req_sel)          state_d = DISABLE;
        else if (settled_sel)  state_d = RAMP;
        else if (cnt_q == '0) begin
          state_d       = DISABLE;
          timeout_err_d = 1'b1;
        end
      end
      RAMP: begin
        if (!req_sel)          state_d = DISABLE;
        else if (cnt_q == '0)  state_d = RX;
      end
      RX: begin
        if (!req_sel)          state_d = DISABLE;
      end
      DISABLE: begin
        state_d = IDLE;
        ptr_d   = (sel_q == IW'(BIT_WIDTH - 1)) ? '0 : sel_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        ISO_RELEASE: cnt_d = CW'(ISO_CYCLES - 1);
        PLL_WAIT:    cnt_d = CW'(PLL_TIMEOUT - 1);
        RAMP:        cnt_d = CW'(RAMP_CYCLES - 1);
        default:     cnt_d = '0;
      endcase
    end

    grant_d    = (state_d == IDLE) ? '0 : ((state_q == IDLE) ? arb_grant : grant_q);
    radio_en_d = (state_d == RAMP || state_d == RX) ? grant_d : '0;
    rx_en_d    = (state_d == RX) ? grant_d : '0;
    isolate_d  = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      ptr_q         <= '0;
      grant_q       <= '0;
      radio_en_q    <= '0;
      rx_en_q       <= '0;
      isolate_q     <= 1'b1;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      radio_en_q    <= radio_en_d;
      rx_en_q       <= rx_en_d;
      isolate_q     <= isolate_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign radioEnable = radio_en_q;
  assign radioRxEn   = rx_en_q;
  assign isolate     = isolate_q;
  assign busy        = busy_q;
  assign timeoutErr  = timeout_err_q;

  a_grant_oh: assert property (@(posedge ck) disable iff (!arst) $onehot0(grant_q));
  a_en_oh:    assert property (@(posedge ck) disable iff (!arst) $onehot0(radio_en_q));
  a_rx_oh:    assert property (@(posedge ck) disable iff (!arst) $onehot0(rx_en_q));
  a_rx_en:    assert property (@(posedge ck) disable iff (!arst) (rx_en_q & ~radio_en_q) == '0);
  a_iso_en:   assert property (@(posedge ck) disable iff (!arst) !(isolate_q && (radio_en_q != '0)));

endmodule

// File: tb/tb_radio_enable_sequencer.sv
// Directed bench: stimulus queues expected output changes, a negedge monitor pops and compares them.
module tb_radio_enable_sequencer;

  logic       ck;
  logic       arst;
  logic [1:0] req, pllSettled;
  logic [1:0] grant, radioEnable, radioRxEn;
  logic       isolate, busy, timeoutErr;

  radio_enable_sequencer #(
    .BIT_WIDTH(2), .ISO_CYCLES(4), .RAMP_CYCLES(8), .PLL_TIMEOUT(64)
  ) dut (
    .ck          (ck),
    .arst        (arst),
    .req         (req),
    .pllSettled  (pllSettled),
    .grant       (grant),
    .radioEnable (radioEnable),
    .radioRxEn   (radioRxEn),
    .isolate     (isolate),
    .busy        (busy),
    .timeoutErr  (timeoutErr)
  );

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } ev_t;

  ev_t        q[$];
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;
  logic [8:0] snap;
  logic [8:0] prev  = 'x;
  localparam logic [8:0] RST_V = 9'b00_00_00_1_0_0;

  initial ck = 1'b0;
  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  // cyc == -1 means "timing not checked" (used for the power-on reset event).
  task automatic push(input int c, input logic [1:0] g, input logic [1:0] en, input logic [1:0] rx,
                      input logic iso, input logic bz, input logic to);
    ev_t e;
    e.cyc = c;
    e.v   = {g, en, rx, iso, bz, to};
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  always @(negedge ck) begin
    snap = {grant, radioEnable, radioRxEn, isolate, busy, timeoutErr};
    if (snap !== prev) begin
      prev = snap;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, snap);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (snap !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
          bad++;
          $display("FAIL output_event cyc=%0d got=%b required=%b at cyc=%0d", cyc, snap, e.v, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, r, b;
    arst = 1'b0; req = 2'b00; pllSettled = 2'b00;
    push(-1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    arst = 1'b1;
    tick();

    // Rotation with both lanes requesting; PLL already settled.
    pllSettled = 2'b11;
    e = cyc + 1;
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      logic [1:0] g;
      b = e + 16 * k;
      g = (k == 1) ? 2'b10 : 2'b01;
      push(b,      g, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      push(b + 5,  g, g,     2'b00, 1'b0, 1'b1, 1'b0);
      push(b + 13, g, g,     g,     1'b0, 1'b1, 1'b0);
      push(b + 14, g, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      push(b + 15, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      logic [1:0] g;
      b = e + 16 * k;
      g = (k == 1) ? 2'b10 : 2'b01;
      wait_until(b + 13);
      req = (k == 2) ? 2'b00 : (req & ~g);
      wait_until(b + 14);
      if (k < 2) req = req | g;
    end
    wait_until(e + 49);
    pllSettled = 2'b00;
    tick();

    // Lane0, PLL settles in the 10th PLL_WAIT cycle.
    e = cyc + 1;
    req = 2'b01;
    push(e,      2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 14, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 22, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
    push(e + 25, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 26, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    wait_until(e + 13);
    pllSettled = 2'b01;
    wait_until(e + 24);
    req = 2'b00; pllSettled = 2'b00;
    wait_until(e + 27);

    // PLL never settles: timeout after 64 PLL_WAIT cycles.
    e = cyc + 1;
    req = 2'b01;
    push(e,      2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 68, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    push(e + 69, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    wait_until(e + 68);
    req = 2'b00;
    wait_until(e + 70);

    // PLL settled before request (1-cycle PLL_WAIT); request dropped in 3rd RAMP cycle.
    pllSettled = 2'b01;
    tick();
    e = cyc + 1;
    req = 2'b01;
    push(e,     2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 5, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 8, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 9, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    wait_until(e + 7);
    req = 2'b00;
    wait_until(e + 10);
    pllSettled = 2'b00;

    // Asynchronous reset during RX on lane1; pointer must return to lane0.
    e = cyc + 1;
    req = 2'b10; pllSettled = 2'b10;
    r = e + 15;
    push(e,      2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 5,  2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    push(e + 13, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0);
    push(r,      2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push(r + 3,  2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(r + 8,  2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
    push(r + 10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    push(r + 11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    wait_until(r);
    #2 arst = 1'b0;
    #1;
    total++;
    if ({grant, radioEnable, radioRxEn, isolate, busy, timeoutErr} !== RST_V) begin
      bad++;
      $display("FAIL async_reset got=%b required=%b", {grant, radioEnable, radioRxEn, isolate, busy, timeoutErr}, RST_V);
    end
    wait_until(r + 2);
    arst = 1'b1; req = 2'b11; pllSettled = 2'b11;
    wait_until(r + 9);
    req = 2'b00;
    wait_until(r + 12);
    pllSettled = 2'b00;

    for (int k = 0; k < 100 && q.size() != 0; k++) tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d required=0", q.size());
    end
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
